// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: 200 MHz protocol timing, receiver FSM encoding,
// and the GRB<->RGB byte order used by both transmitter and receiver.
package ws2812_pkg;

  localparam int WS_T0H    = 80;
  localparam int WS_T1H    = 160;
  localparam int WS_TBIT   = 250;
  localparam int WS_TRESET = 10000;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } rx_state_e;

  // Wire order is G,R,B; both directions only swap the top two bytes.
  function automatic logic [23:0] rgb2grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

  function automatic logic [23:0] grb2rgb(input logic [23:0] grb);
    return {grb[15:8], grb[23:16], grb[7:0]};
  endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// Serial line in, decoded pixel stream and status out.
interface ws2812_rx_if #(
  parameter int IDX_W = 10
) ();
  logic             ws;
  logic [23:0]      RGB_data;
  logic             dv;
  logic [IDX_W-1:0] pixel_idx;
  logic             frame_end;
  logic             err;
  logic             locked;

  modport master (output ws, input RGB_data, dv, pixel_idx, frame_end, err, locked);
  modport slave  (input ws, output RGB_data, dv, pixel_idx, frame_end, err, locked);
endinterface

// File: rtl/ws2812_rx_sync_edge.sv
// Two-flop synchroniser for the async ws line, registered level and
// single-cycle rise/fall pulses derived from it.
module ws_sync_edge (
  input  logic clk,
  input  logic restn,
  input  logic ws_i,
  output logic ws_s_o,
  output logic rise_o,
  output logic fall_o
);
  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk) begin
    if (!restn) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= ws_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign ws_s_o = s2_q;
  assign rise_o = s2_q & ~prev_q;
  assign fall_o = ~s2_q & prev_q;
endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: measures each high pulse, assembles 24-bit GRB words,
// emits RGB pixels with a per-frame index, and frames on the reset gap.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int T_MIN_HIGH = 30,
  parameter int T_THRESH   = (WS_T0H + WS_T1H) / 2,
  parameter int T_MAX_HIGH = 300,
  parameter int T_RESET    = WS_TRESET,
  parameter int IDX_W      = 10
) (
  input  logic        clk,
  input  logic        restn,
  ws2812_rx_if.slave  bus
);
  localparam logic [8:0]  HI_MIN    = 9'(T_MIN_HIGH);
  localparam logic [8:0]  HI_THR    = 9'(T_THRESH);
  localparam logic [8:0]  HI_MAX_M1 = 9'(T_MAX_HIGH - 1);
  localparam logic [13:0] LO_RST    = 14'(T_RESET);
  localparam logic [13:0] LO_RST_M1 = 14'(T_RESET - 1);

  logic ws_s, rise, fall;

  ws_sync_edge u_sync (
    .clk    (clk),
    .restn  (restn),
    .ws_i   (bus.ws),
    .ws_s_o (ws_s),
    .rise_o (rise),
    .fall_o (fall)
  );

  rx_state_e        state_q;
  logic [13:0]      lo_q;
  logic [8:0]       hi_q;
  logic [4:0]       bit_q;
  logic [23:0]      grb_q;
  logic             done_q;
  logic [23:0]      rgb_q;
  logic             dv_q, fe_q, err_q, locked_q;
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (!restn) begin
      state_q  <= ST_SYNC;
      lo_q     <= '0;
      hi_q     <= '0;
      bit_q    <= '0;
      grb_q    <= '0;
      done_q   <= 1'b0;
      rgb_q    <= '0;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      done_q <= 1'b0;
      dv_q   <= done_q;
      fe_q   <= 1'b0;
      err_q  <= 1'b0;
      if (done_q) rgb_q <= grb2rgb(grb_q);
      // Index stays put for the dv cycle itself, then advances.
      if (dv_q && idx_q != '1) idx_q <= idx_q + IDX_W'(1);

      case (state_q)
        ST_SYNC: begin
          if (ws_s) begin
            lo_q <= '0;
          end else if (lo_q >= LO_RST_M1) begin
            // Counter parks at LO_RST so LOW does not see a fresh crossing.
            lo_q     <= LO_RST;
            bit_q    <= '0;
            idx_q    <= '0;
            locked_q <= 1'b1;
            state_q  <= ST_LOW;
          end else begin
            lo_q <= lo_q + 14'd1;
          end
        end
        ST_LOW: begin
          if (rise) begin
            hi_q    <= 9'd1;  // counts high samples, including the rising one
            state_q <= ST_HIGH;
          end else if (lo_q == LO_RST_M1) begin
            lo_q  <= LO_RST;
            fe_q  <= 1'b1;
            err_q <= (bit_q != 5'd0);
            bit_q <= '0;
            idx_q <= '0;
          end else if (lo_q < LO_RST) begin
            lo_q <= lo_q + 14'd1;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            lo_q    <= 14'd1;
            state_q <= ST_LOW;
            if (hi_q < HI_MIN) begin
              err_q <= 1'b1;
            end else begin
              grb_q <= {grb_q[22:0], hi_q >= HI_THR};
              if (bit_q == 5'd23) begin
                bit_q  <= '0;
                done_q <= 1'b1;
              end else begin
                bit_q <= bit_q + 5'd1;
              end
            end
          end else if (hi_q >= HI_MAX_M1) begin
            err_q    <= 1'b1;
            bit_q    <= '0;
            lo_q     <= '0;
            locked_q <= 1'b0;
            state_q  <= ST_SYNC;
          end else if (hi_q != '1) begin
            hi_q <= hi_q + 9'd1;
          end
        end
        default: begin
          state_q  <= ST_SYNC;
          locked_q <= 1'b0;
          lo_q     <= '0;
        end
      endcase
    end
  end

  assign bus.RGB_data  = rgb_q;
  assign bus.dv        = dv_q;
  assign bus.pixel_idx = idx_q;
  assign bus.frame_end = fe_q;
  assign bus.err       = err_q;
  assign bus.locked    = locked_q;
endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: directed WS2812 waveforms, a pixel scoreboard checked
// every cycle, and literal expectations for each scenario.
`timescale 1ns/100ps
module tb_ws2812_rx;
  localparam int IDX_W = 10;
  localparam int TRST  = 1000;  // shortened reset gap keeps the run compact

  logic clk = 1'b0;
  logic restn = 1'b0;
  always #2.5 clk = ~clk;

  ws2812_rx_if #(.IDX_W(IDX_W)) bus ();

  ws2812_rx #(
    .T_MIN_HIGH(30), .T_THRESH(120), .T_MAX_HIGH(300), .T_RESET(TRST), .IDX_W(IDX_W)
  ) dut (
    .clk   (clk),
    .restn (restn),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [23:0]      rgb;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   ntests = 0, nfail = 0;
  int   cyc = 0;
  int   m_idx = 0;
  int   dv_cnt = 0, err_cnt = 0, fe_cnt = 0;
  int   last_dv_cyc = 0, last_err_cyc = 0, last_fe_cyc = 0, last_fall = 0, rise_cyc = 0;
  logic [23:0]      last_rgb = '0;
  logic [IDX_W-1:0] last_idx = '0;
  logic prev_dv = 1'b0, prev_err = 1'b0, prev_fe = 1'b0;
  int   d0, e0, f0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: GRB on the wire, one RGB pixel out per full word.
  function automatic logic [23:0] to_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

  task automatic expect_word(input logic [23:0] rgb);
    exp_t e;
    e.rgb = rgb;
    e.idx = IDX_W'(m_idx);
    exp_q.push_back(e);
    if (m_idx < (1 << IDX_W) - 1) m_idx++;
  endtask

  always @(negedge clk) begin
    if (restn) begin
      if (bus.dv) begin
        dv_cnt++;
        last_dv_cyc = cyc;
        last_rgb = bus.RGB_data;
        last_idx = bus.pixel_idx;
        chk("dv_width", 32'(prev_dv), 32'd0);
        chk("dv_vs_frame_end", 32'(bus.frame_end), 32'd0);
        if (exp_q.size() == 0) begin
          ntests++;
          nfail++;
          $display("FAIL unexpected_dv: got rgb %06h idx %0d, expected no dv", bus.RGB_data, bus.pixel_idx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_rgb", 32'(bus.RGB_data), 32'(e.rgb));
          chk("sb_idx", 32'(bus.pixel_idx), 32'(e.idx));
        end
      end
      if (bus.err) begin
        err_cnt++;
        last_err_cyc = cyc;
        chk("err_width", 32'(prev_err), 32'd0);
      end
      if (bus.frame_end) begin
        fe_cnt++;
        last_fe_cyc = cyc;
        chk("fe_width", 32'(prev_fe), 32'd0);
      end
    end
    prev_dv  = bus.dv;
    prev_err = bus.err;
    prev_fe  = bus.frame_end;
  end

  task automatic drive(input logic v, input int n);
    bus.ws = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pulse(input int hi, input int lo);
    drive(1'b1, hi);
    last_fall = cyc;
    drive(1'b0, lo);
  endtask

  task automatic send_bits(input logic [23:0] grb, input int nbits);
    for (int i = 23; i > 23 - nbits; i--) begin
      if (grb[i]) send_pulse(160, 90);
      else        send_pulse(80, 170);
    end
  endtask

  task automatic send_rgb(input logic [23:0] rgb);
    send_bits(to_grb(rgb), 24);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rgb"},    32'(bus.RGB_data),  32'd0);
    chk({tag, "_dv"},     32'(bus.dv),        32'd0);
    chk({tag, "_idx"},    32'(bus.pixel_idx), 32'd0);
    chk({tag, "_fe"},     32'(bus.frame_end), 32'd0);
    chk({tag, "_err"},    32'(bus.err),       32'd0);
    chk({tag, "_locked"}, 32'(bus.locked),    32'd0);
  endtask

  initial begin
    bus.ws = 1'b0;
    restn  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    restn = 1'b1;

    // Initial sync on a long low: locks, but no frame_end.
    drive(1'b0, TRST + 500);
    chk("sync_locked", 32'(bus.locked), 32'd1);
    chk("sync_no_fe", 32'(fe_cnt), 32'd0);
    m_idx = 0;

    // Single pixel, wire order GRB 0x341256.
    d0 = dv_cnt; e0 = err_cnt;
    expect_word(24'h123456);
    send_bits(24'h341256, 24);
    chk("t1_dv_count", 32'(dv_cnt - d0), 32'd1);
    chk("t1_rgb", 32'(last_rgb), 32'h123456);
    chk("t1_idx", 32'(last_idx), 32'd0);
    chk("t1_err", 32'(err_cnt - e0), 32'd0);
    chk("t1_latency", 32'(last_dv_cyc - last_fall), 32'd4);
    f0 = fe_cnt;
    drive(1'b0, TRST + 200);
    m_idx = 0;
    chk("t1_fe", 32'(fe_cnt - f0), 32'd1);

    // Three pixels then a reset gap.
    d0 = dv_cnt; f0 = fe_cnt;
    expect_word(24'hFF0000); send_rgb(24'hFF0000);
    expect_word(24'h00FF00); send_rgb(24'h00FF00);
    expect_word(24'h0000FF); send_rgb(24'h0000FF);
    chk("t2_idx_last", 32'(last_idx), 32'd2);
    chk("t2_rgb_last", 32'(last_rgb), 32'h0000FF);
    drive(1'b0, TRST + 100);
    m_idx = 0;
    chk("t2_dv_count", 32'(dv_cnt - d0), 32'd3);
    chk("t2_fe_count", 32'(fe_cnt - f0), 32'd1);
    chk("t2_fe_delay", 32'((last_fe_cyc - last_fall >= TRST) && (last_fe_cyc - last_fall <= TRST + 4)), 32'd1);

    // Boundary widths: 119 -> 0, 29 -> err and dropped, 120 -> 1.
    d0 = dv_cnt; e0 = err_cnt;
    expect_word(24'h3C5A81);
    send_bits(24'h5A3C81, 22);
    send_pulse(119, 131);
    send_pulse(29, 100);
    send_pulse(120, 130);
    chk("t3_err", 32'(err_cnt - e0), 32'd1);
    chk("t3_dv_count", 32'(dv_cnt - d0), 32'd1);
    chk("t3_rgb", 32'(last_rgb), 32'h3C5A81);
    drive(1'b0, TRST + 200);
    m_idx = 0;

    // Stuck high mid-word: timeout error, unlock, relock on a fresh gap.
    d0 = dv_cnt; e0 = err_cnt;
    send_bits(24'hAAAAAA, 10);
    rise_cyc = cyc;
    drive(1'b1, 400);
    chk("t4_err", 32'(err_cnt - e0), 32'd1);
    chk("t4_err_time", 32'((last_err_cyc - rise_cyc >= 298) && (last_err_cyc - rise_cyc <= 306)), 32'd1);
    chk("t4_unlocked", 32'(bus.locked), 32'd0);
    drive(1'b0, 300);
    send_rgb(24'h00FF00);
    chk("t4_ignored_dv", 32'(dv_cnt - d0), 32'd0);
    chk("t4_still_unlocked", 32'(bus.locked), 32'd0);
    f0 = fe_cnt;
    drive(1'b0, TRST + 200);
    m_idx = 0;
    chk("t4_relocked", 32'(bus.locked), 32'd1);
    chk("t4_no_fe", 32'(fe_cnt - f0), 32'd0);

    // Partial word closed by a reset gap.
    d0 = dv_cnt; e0 = err_cnt; f0 = fe_cnt;
    send_bits(24'hF0F0F0, 12);
    drive(1'b0, TRST + 200);
    m_idx = 0;
    chk("t5_err", 32'(err_cnt - e0), 32'd1);
    chk("t5_fe", 32'(fe_cnt - f0), 32'd1);
    chk("t5_same_cycle", 32'(last_err_cyc), 32'(last_fe_cyc));
    chk("t5_no_dv", 32'(dv_cnt - d0), 32'd0);
    expect_word(24'hC0FFEE);
    send_rgb(24'hC0FFEE);
    chk("t5_next_idx", 32'(last_idx), 32'd0);
    chk("t5_next_rgb", 32'(last_rgb), 32'hC0FFEE);
    drive(1'b0, TRST + 200);
    m_idx = 0;

    // Reset mid-word after one good pixel.
    d0 = dv_cnt;
    expect_word(24'h0A0B0C);
    send_rgb(24'h0A0B0C);
    send_bits(24'h555555, 10);
    chk("t6_idx_before", 32'(bus.pixel_idx), 32'd1);
    restn = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("t6_reset");
    restn = 1'b1;
    send_bits(24'hFFFFFF, 6);
    drive(1'b0, 100);
    chk("t6_ignored", 32'(dv_cnt - d0), 32'd1);
    chk("t6_unlocked", 32'(bus.locked), 32'd0);
    drive(1'b0, TRST + 200);
    m_idx = 0;
    chk("t6_relocked", 32'(bus.locked), 32'd1);
    expect_word(24'h102030);
    send_rgb(24'h102030);
    chk("t6_after_rgb", 32'(last_rgb), 32'h102030);
    chk("t6_after_idx", 32'(last_idx), 32'd0);
    drive(1'b0, TRST + 200);

    chk("all_dv_seen", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Receiver/decoder for the single-wire WS2812 LED protocol, the counterpart of the team's 24-bit WS2812 transmitter. It samples the serial `ws` line on the 200 MHz fabric clock and classifies each high pulse as a 0 or 1 bit. It assembles 24-bit GRB words, reorders them to RGB, and emits one word per `dv` pulse. It sits in loopback test paths and LED-chain monitors, and frames pixels using the protocol reset gap.

## Interface
Parameters:
- `T_MIN_HIGH`, default 30: minimum valid high width, in cycles (0.15 µs).
- `T_THRESH`, default 120: high width ≥ this decodes as 1; below it decodes as 0 (0.6 µs).
- `T_MAX_HIGH`, default 300: high width ≥ this is an error (1.5 µs).
- `T_RESET`, default 10000: low width ≥ this is a frame reset (50 µs).
- `IDX_W`, default 10: width of the pixel index.

Ports:
- `clk`, in, 1: 200 MHz clock.
- `restn`, in, 1: synchronous, active-low reset.
- `ws`, in, 1: asynchronous serial line.
- `RGB_data`, out, 24: last decoded pixel, `{R,G,B}`.
- `dv`, out, 1: one-cycle strobe; `RGB_data` is valid in the same cycle.
- `pixel_idx`, out, IDX_W: index of the pixel in `RGB_data`, counted within the current frame.
- `frame_end`, out, 1: one-cycle pulse when a reset gap closes a frame.
- `err`, out, 1: one-cycle pulse on any protocol violation.
- `locked`, out, 1: high when the receiver is synchronised (not in SYNC).

## Operation
- `ws` passes through a 2-flop synchroniser plus edge detection to give `ws_s`, `rise` and `fall`.
- Shift register `grb[23:0]` takes bits MSB first. `bit_cnt` counts 0..23.
- Output reorder: `RGB_data = {grb[15:8], grb[23:16], grb[7:0]}`.
- FSM states:
  - SYNC (entered at reset): the low counter runs while `ws_s`=0 and clears on `ws_s`=1. When the count reaches `T_RESET`, go to LOW with `bit_cnt`=0 and `pixel_idx`=0. No `frame_end` is issued.
  - LOW: the low counter runs.
    - On `rise`: clear the high counter and go to HIGH.
    - When the low counter reaches `T_RESET`: pulse `frame_end` once. If `bit_cnt`≠0, also pulse `err` and discard the partial word. Clear `bit_cnt` and `pixel_idx`, and stay in LOW with the counter saturated. Only the first crossing pulses.
  - HIGH: the high counter runs.
    - On `fall` with width < `T_MIN_HIGH`: pulse `err`, drop the bit, return to LOW.
    - On `fall` otherwise: shift in `(width ≥ T_THRESH)`, increment `bit_cnt`, clear the low counter, go to LOW.
    - When the count reaches `T_MAX_HIGH` before `fall`: pulse `err`, clear `bit_cnt`, go to SYNC.
- Word completion: the fall that shifts in bit 24 loads the output register, pulses `dv` on the next cycle, and presents the current `pixel_idx`. After `dv`, `pixel_idx` increments and saturates at 2^IDX_W−1, and `bit_cnt` returns to 0.
- Counter widths: low counter 14 bits, high counter 9 bits. Both saturate and never wrap.
- Simultaneous events: `frame_end` and `err` may pulse in the same cycle. `dv` never coincides with `frame_end`.
- Reset mid-word: any `restn`=0 cycle returns the block to SYNC, with the partial word lost.

## Timing
- Reset values: `RGB_data`=0, `dv`=0, `pixel_idx`=0, `frame_end`=0, `err`=0, `locked`=0.
- The synchroniser delays `ws` by 2 cycles.
- The pulse-width measurement is exact to ±1 cycle of the `ws` edges.
- Latency from the final falling edge of `ws` to `dv`: 4 cycles (2 synchroniser, 1 edge detect/shift, 1 output register).
- `dv`, `frame_end` and `err` are each exactly one cycle wide. There is no backpressure: the consumer must accept each `dv`.
- Minimum bit period accepted: `T_MIN_HIGH` + 2 low cycles.
- `locked` rises in the cycle SYNC exits.

## Structure
- Shared package `ws2812_pkg`:
  - Timing constants (T0H=80, T1H=160, TBIT=250, T_RESET=10000 cycles at 200 MHz).
  - The FSM state encoding.
  - The functions `rgb2grb` and `grb2rgb`, so the transmitter and receiver share the byte order.
- Sub-module `ws_sync_edge`: 2-flop synchroniser, registered level output, and `rise`/`fall` pulses.

## Test plan
- **Single pixel.** After a 12000-cycle low, drive RGB 0x123456 (GRB 0x341256) with 1 = 160 high/90 low and 0 = 80 high/170 low. Required: one `dv`, `RGB_data`=0x123456, `pixel_idx`=0, `err`=0.
- **Three pixels then reset.** Drive 0xFF0000, 0x00FF00, 0x0000FF followed by a 10000-cycle low. Required: `dv` at `pixel_idx` 0, 1, 2 with matching data, then exactly one `frame_end` 10000 cycles after the last fall.
- **Boundary widths.** Drive highs of 119 and 120 cycles. Required: bits 0 and 1. A high of 29 cycles gives an `err` pulse and no bit.
- **Stuck high.** Hold `ws` high for 400 cycles mid-word. Required: `err` at cycle 300, `locked`=0, no `dv` until a new 10000-cycle low, after which `locked`=1.
- **Partial word.** Send 12 bits, then a 10000-cycle low. Required: `err` and `frame_end` in the same cycle, no `dv`, and the next full word decodes at `pixel_idx`=0.
- **Reset mid-word.** Assert `restn`=0 for 1 cycle after bit 10. Required: all outputs return to their reset values, and bits before the next 10000-cycle low are ignored.
